// File: rtl/fetch_pkg.sv
// Shared types and width helpers for the W/B/I tile-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fetch_state_e;

  localparam int LANE_WIDTH = 32;

  // Number of 32-bit host lanes packed into one read word.
  function automatic int calc_ratio(input int data_width);
    return data_width / LANE_WIDTH;
  endfunction

  // Host-side address width: one extra bit per doubling of the lane count.
  function automatic int calc_a_addr_width(input int addr_width, input int data_width);
    return addr_width + $clog2(calc_ratio(data_width));
  endfunction

endpackage

// File: rtl/fetch_bram_w_b_i_top_if.sv
// Host write port and loader-facing fetch signals of the tile-fetch front end.
interface fetch_bram_w_b_i_top_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 256
) ();
  import fetch_pkg::*;

  localparam int A_ADDR_WIDTH = calc_a_addr_width(ADDR_WIDTH, DATA_WIDTH);

  logic                    start_fetch;
  logic                    reset_addr_counter;
  logic                    ena;
  logic                    wea;
  logic [A_ADDR_WIDTH-1:0] addra;
  logic [31:0]             dina;
  logic                    fetch_done;
  logic [DATA_WIDTH-1:0]   doutb;
  logic [ADDR_WIDTH-1:0]   addrb;

  modport master (
    output start_fetch, reset_addr_counter, ena, wea, addra, dina,
    input  fetch_done, doutb, addrb
  );

  modport slave (
    input  start_fetch, reset_addr_counter, ena, wea, addra, dina,
    output fetch_done, doutb, addrb
  );

endinterface

// File: rtl/bram_sdp_asym.sv
// Simple dual-port RAM: 32-bit write port, DATA_WIDTH registered read port.
module bram_sdp_asym
  import fetch_pkg::*;
#(
  parameter  int ADDR_WIDTH   = 11,
  parameter  int DATA_WIDTH   = 256,
  localparam int RATIO        = calc_ratio(DATA_WIDTH),
  localparam int A_ADDR_WIDTH = calc_a_addr_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_a,
  input  logic [A_ADDR_WIDTH-1:0] addr_a,
  input  logic [31:0]             din_a,
  input  logic                    re_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  output logic [DATA_WIDTH-1:0]   dout_b
);

  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_word;
  logic [LANE_W-1:0]     wr_lane;

  // Host address RATIO*k+j lands in lane j (LSB lane first) of word k.
  assign wr_word = ADDR_WIDTH'(addr_a / A_ADDR_WIDTH'(RATIO));
  assign wr_lane = LANE_W'(addr_a % A_ADDR_WIDTH'(RATIO));

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[wr_word][wr_lane*32 +: 32] <= din_a;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_b <= '0;
    end else if (re_b) begin
      dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/fetch_bram_w_b_i_top.sv
// Tile-fetch front end: host-written BRAM plus a controller that streams one
// tile of consecutive wide words per fetch command from a persistent counter.
module fetch_bram_w_b_i_top
  import fetch_pkg::*;
#(
  parameter int NUM_FETCHES_PER_TILE = 32,
  parameter int ADDR_WIDTH           = 11,
  parameter int FETCH_START_OFFSET   = 112,
  parameter int DATA_WIDTH           = 256
) (
  input logic                   clk,
  input logic                   rst,
  fetch_bram_w_b_i_top_if.slave bus
);

  localparam int                  BEAT_W    = $clog2(NUM_FETCHES_PER_TILE + 1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(NUM_FETCHES_PER_TILE - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFSET  = ADDR_WIDTH'(FETCH_START_OFFSET);

  fetch_state_e          state, next_state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [BEAT_W-1:0]     beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state takes its default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start_fetch) next_state = FETCH;
      FETCH:   if (beat == LAST_BEAT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The address counter survives between fetches so successive commands walk
  // successive tiles; only an explicit clear outside FETCH rewinds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      beat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_fetch)        beat <= '0;
          if (bus.reset_addr_counter) cnt  <= '0;
        end
        FETCH: begin
          cnt  <= cnt + 1'b1;
          beat <= beat + 1'b1;
        end
        DONE: begin
          if (bus.reset_addr_counter) cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.addrb      = OFFSET + cnt;
  assign bus.fetch_done = (state == DONE);

  bram_sdp_asym #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bram (
    .clk    (clk),
    .rst    (rst),
    .we_a   (bus.ena && bus.wea),
    .addr_a (bus.addra),
    .din_a  (bus.dina),
    .re_b   (state == FETCH),
    .addr_b (bus.addrb),
    .dout_b (bus.doutb)
  );

endmodule

// File: tb/tb_fetch_bram_w_b_i_top.sv
// Self-checking bench for fetch_bram_w_b_i_top against a memory/counter model.
module tb_fetch_bram_w_b_i_top;

  localparam int N      = 32;
  localparam int AW     = 11;
  localparam int OFFSET = 112;
  localparam int DW     = 256;
  localparam int RATIO  = DW / 32;
  localparam int DEPTH  = 2 ** AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_bram_w_b_i_top_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_bram_w_b_i_top #(
    .NUM_FETCHES_PER_TILE (N),
    .ADDR_WIDTH           (AW),
    .FETCH_START_OFFSET   (OFFSET),
    .DATA_WIDTH           (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: flat 32-bit host memory plus the tile counter.
  logic [31:0] mref [DEPTH*RATIO];
  int          m_cnt;
  int          errors;
  int          checks;

  function automatic logic [DW-1:0] exp_word(input int w);
    logic [DW-1:0] r;
    for (int j = 0; j < RATIO; j++) r[32*j +: 32] = mref[w*RATIO + j];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [31:0] d, input logic en, input logic we);
    bus.ena   = en;
    bus.wea   = we;
    bus.addra = 14'(a);
    bus.dina  = d;
    tick();
    bus.ena = 1'b0;
    bus.wea = 1'b0;
    if (en && we) mref[a] = d;
  endtask

  task automatic idle_check(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      tick();
      checks++;
      if (bus.fetch_done !== 1'b0) begin
        errors++;
        $display("FAIL %s: fetch_done=%b required 0", name, bus.fetch_done);
      end
    end
  endtask

  // One fetch command with optional busy-time pokes, reset, or a write in the command cycle.
  task automatic do_fetch(input string name, input int busy_beat, input int rst_beat, input bit wr_at_start);
    int cnt0;
    int done_cnt;
    int ea;
    cnt0     = m_cnt;
    done_cnt = 0;
    if (wr_at_start) begin
      bus.ena   = 1'b1;
      bus.wea   = 1'b1;
      bus.addra = 14'(((OFFSET + cnt0) % DEPTH) * RATIO + $urandom_range(0, RATIO - 1));
      bus.dina  = $urandom;
      mref[int'(bus.addra)] = bus.dina;
    end
    bus.start_fetch = 1'b1;
    tick();
    bus.start_fetch = 1'b0;
    bus.ena = 1'b0;
    bus.wea = 1'b0;
    for (int k = 0; k < N; k++) begin
      ea = (OFFSET + cnt0 + k) % DEPTH;
      checks++;
      if (bus.addrb !== AW'(ea)) begin
        errors++;
        $display("FAIL %s addrb beat %0d: got %0d required %0d", name, k, bus.addrb, ea);
      end
      if (k == busy_beat) begin
        bus.start_fetch        = 1'b1;
        bus.reset_addr_counter = 1'b1;
      end
      if (k == rst_beat) rst = 1'b1;
      tick();
      bus.start_fetch        = 1'b0;
      bus.reset_addr_counter = 1'b0;
      if (k == rst_beat) begin
        rst   = 1'b0;
        m_cnt = 0;
        checks += 3;
        if (bus.fetch_done !== 1'b0) begin
          errors++;
          $display("FAIL %s reset fetch_done: got %b required 0", name, bus.fetch_done);
        end
        if (bus.doutb !== '0) begin
          errors++;
          $display("FAIL %s reset doutb: got %h required 0", name, bus.doutb);
        end
        if (bus.addrb !== AW'(OFFSET)) begin
          errors++;
          $display("FAIL %s reset addrb: got %0d required %0d", name, bus.addrb, OFFSET);
        end
        idle_check(N + 4, {name, " no done after reset"});
        return;
      end
      checks += 2;
      if (bus.doutb !== exp_word(ea)) begin
        errors++;
        $display("FAIL %s doutb beat %0d: got %h required %h", name, k, bus.doutb, exp_word(ea));
      end
      if (bus.fetch_done !== (k == N - 1)) begin
        errors++;
        $display("FAIL %s fetch_done beat %0d: got %b required %b", name, k, bus.fetch_done, k == N - 1);
      end
      if (bus.fetch_done === 1'b1) done_cnt++;
    end
    tick();
    m_cnt = (cnt0 + N) % DEPTH;
    checks += 3;
    if (bus.fetch_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done width: fetch_done=%b required 0", name, bus.fetch_done);
    end
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done count: got %0d required 1", name, done_cnt);
    end
    if (bus.addrb !== AW'((OFFSET + m_cnt) % DEPTH)) begin
      errors++;
      $display("FAIL %s end addrb: got %0d required %0d", name, bus.addrb, (OFFSET + m_cnt) % DEPTH);
    end
  endtask

  task automatic pulse_counter_reset();
    bus.reset_addr_counter = 1'b1;
    tick();
    bus.reset_addr_counter = 1'b0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    m_cnt = 0;
    checks += 3;
    if (bus.fetch_done !== 1'b0) begin
      errors++;
      $display("FAIL reset fetch_done: got %b required 0", bus.fetch_done);
    end
    if (bus.doutb !== '0) begin
      errors++;
      $display("FAIL reset doutb: got %h required 0", bus.doutb);
    end
    if (bus.addrb !== AW'(OFFSET)) begin
      errors++;
      $display("FAIL reset addrb: got %0d required %0d", bus.addrb, OFFSET);
    end
  endtask

  task automatic test_fill_fetch();
    pulse_counter_reset();
    for (int i = 0; i < 4096; i++) write_word(896 + i, 32'(2 * i + 2), 1'b1, 1'b1);
    do_fetch("fill_fetch", -1, -1, 1'b0);
  endtask

  task automatic test_second_fetch();
    idle_check($urandom_range(0, 4), "gap before second fetch");
    do_fetch("second_fetch", -1, -1, 1'b0);
  endtask

  task automatic test_counter_reset();
    pulse_counter_reset();
    do_fetch("counter_reset", -1, -1, 1'b0);
  endtask

  task automatic test_busy_inputs();
    do_fetch("busy_inputs", int'($urandom_range(1, N - 2)), -1, 1'b0);
    idle_check(3, "busy start not queued");
    do_fetch("after_busy", -1, -1, 1'b0);
  endtask

  // Random host writes into the next tile, including gated-off enables and a write in the command cycle.
  task automatic test_random_writes();
    int base;
    base = (OFFSET + m_cnt) % DEPTH;
    for (int i = 0; i < 24; i++) begin
      write_word(((base + int'($urandom_range(0, N - 1))) % DEPTH) * RATIO + int'($urandom_range(0, RATIO - 1)),
                 $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    do_fetch("random_writes", -1, -1, 1'b1);
  endtask

  task automatic test_wrap();
    for (int w = 0; w < OFFSET; w++)
      for (int j = 0; j < RATIO; j++) write_word(w * RATIO + j, $urandom, 1'b1, 1'b1);
    for (int w = OFFSET + 4096 / RATIO; w < DEPTH; w++)
      for (int j = 0; j < RATIO; j++) write_word(w * RATIO + j, $urandom, 1'b1, 1'b1);
    pulse_counter_reset();
    for (int f = 0; f < 61; f++) do_fetch($sformatf("wrap_%0d", f), -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    do_fetch("reset_mid_fetch", -1, 10, 1'b0);
    do_fetch("after_reset", -1, -1, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.start_fetch        = 1'b0;
    bus.reset_addr_counter = 1'b0;
    bus.ena   = 1'b0;
    bus.wea   = 1'b0;
    bus.addra = '0;
    bus.dina  = '0;
    test_reset();
    test_fill_fetch();
    test_second_fetch();
    test_counter_reset();
    test_busy_inputs();
    test_random_writes();
    test_wrap();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
